gate_vec_unit: RTL
==================

# gate_vec_unit

Parametrised, registered successor to the two-input basic-gate block. It applies one of eight selectable bitwise gate functions to WIDTH-bit operands and delivers the result through a valid/ready handshake with a one-entry output register. An autonomous sweep mode steps the operands through every input combination at a programmable rate, so the lab board can display a full truth table on LEDs. It sits between the board switch/debounce logic and the LED/seven-segment output stage.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (1..8).
- SWEEP_DIV, 1000000, CLK cycles between sweep steps (≥2).

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, asynchronous, active-high.
- SWEEP  in  1  mode select: 0 = direct, 1 = sweep (level).
- OP  in  3  function: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A.
- A  in  WIDTH  operand A (direct mode).
- B  in  WIDTH  operand B (direct mode).
- IN_VALID  in  1  A/B/OP valid (direct mode).
- IN_READY  out  1  unit accepts A/B/OP this cycle.
- Y  out  WIDTH  registered result.
- Y_A  out  WIDTH  operand A that produced Y.
- Y_B  out  WIDTH  operand B that produced Y.
- OUT_VALID  out  1  Y/Y_A/Y_B hold an unconsumed result.
- OUT_READY  in  1  consumer takes result.
- SWEEP_DONE  out  1  one-cycle pulse when the sweep index wraps.

## Operation
- Function evaluation is combinational on the accepted operands. Per bit: AND a&b, NAND ~(a&b), OR a|b, NOR ~(a|b), XOR a^b, XNOR ~(a^b), NOT ~a, PASS a. B is ignored for OP 6/7. OP is sampled together with the operands.
- Output slot: one register. The slot is free when OUT_VALID=0 or OUT_READY=1 (consume and refill in the same cycle are allowed).
- States: IDLE (direct mode), SWEEP_RUN, DRAIN.
- IDLE:
  - IN_READY = slot free.
  - Transfer on IN_VALID & IN_READY: load Y, Y_A and Y_B, and set OUT_VALID.
  - If SWEEP=1 and OUT_VALID=0: go to SWEEP_RUN with index=0 and prescaler=0. If SWEEP=1 while a result is pending, stay in IDLE until it is consumed; new direct inputs are still accepted until the transition.
- SWEEP_RUN:
  - IN_READY=0.
  - Index is 2·WIDTH bits: operand A = index[WIDTH-1:0], operand B = index[2·WIDTH-1:WIDTH]. OP is sampled live at each step.
  - Prescaler counts 0..SWEEP_DIV-1. At terminal count, if the slot is free, issue the step into the slot, increment the index and reset the prescaler to 0. If the slot is not free, the prescaler holds at terminal count (back-pressure stalls the sweep; no step is dropped or skipped).
  - When the issued index is all-ones, the index wraps to 0 and SWEEP_DONE pulses in the same cycle as the issue.
  - SWEEP=0: go to DRAIN.
- DRAIN: IN_READY=0. Go to IDLE once OUT_VALID=0 (or the pending result is consumed this cycle). Index and prescaler are cleared.
- Reset (any time, including mid-sweep or mid-handshake): state=IDLE, OUT_VALID=0, Y=Y_A=Y_B=0, SWEEP_DONE=0, index=0, prescaler=0. IN_READY=0 while RST=1 and 1 in the first cycle after release.

## Timing
- Direct latency: transfer at edge n, so Y and OUT_VALID are valid after edge n (one cycle). With OUT_READY held at 1, throughput is 1 result per cycle.
- Y, Y_A and Y_B are stable while OUT_VALID=1 and OUT_READY=0.
- Sweep: with OUT_READY=1, consecutive steps are issued exactly SWEEP_DIV cycles apart. The first step is issued SWEEP_DIV cycles after entry to SWEEP_RUN. A full pass takes 2^(2·WIDTH)·SWEEP_DIV cycles.
- IN_READY is a function of registered state and OUT_READY only; there is no combinational path from IN_VALID.
- All outputs are registered except IN_READY.

## Test plan
- Reset values: assert RST mid-stream with OUT_VALID=1 → Y=0, OUT_VALID=0, SWEEP_DONE=0 asynchronously; IN_READY=1 one cycle after release.
- Direct, WIDTH=4: A=4'b1100, B=4'b1010, OP=0..7 back-to-back with OUT_READY=1 → Y = 1000, 0111, 1110, 0001, 0110, 1001, 0011, 1100 on consecutive cycles. Y_A and Y_B echo the operands.
- Back-pressure: OUT_READY=0 after the first transfer (OP=4, A=3, B=5) → Y=6 held and IN_READY=0. Second request A=F, B=0 is held; after OUT_READY=1 → Y=F one cycle later and no data lost.
- Sweep, WIDTH=2, SWEEP_DIV=3, OP=XOR, OUT_READY=1 → 16 results 3 cycles apart. Y_A/Y_B run 0/0, 1/0 … 3/3 with Y = Y_A^Y_B. SWEEP_DONE pulses with the 16th result, then the index restarts at 0/0.
- Sweep stall: OUT_READY=0 for 10 cycles at a step → index frozen and the next step is issued on the cycle OUT_READY rises. No index is skipped.
- Mode change: drop SWEEP while a result is pending → DRAIN holds IN_READY=0 until the result is consumed, then IDLE. A re-entered sweep restarts at index 0.

Source files
------------

// File: rtl/gate_vec_unit.sv
// Registered bitwise gate unit: eight selectable gate functions on WIDTH-bit operands,
// one-entry output register with valid/ready handshake, and an autonomous truth-table sweep.
//
// state        | meaning
// ST_IDLE      | direct mode, operands accepted from A/B/OP
// ST_SWEEP_RUN | operands generated from the sweep index at the prescaled rate
// ST_DRAIN     | sweep left, waiting for the pending result to be consumed
module gate_vec_unit #(
    parameter int WIDTH     = 4,
    parameter int SWEEP_DIV = 1000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SWEEP,
    input  logic [2:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_A,
    output logic [WIDTH-1:0] Y_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             SWEEP_DONE
);

    localparam int IDX_W = 2 * WIDTH;
    localparam int PRE_W = (SWEEP_DIV > 2) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(SWEEP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP_RUN,
        ST_DRAIN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_idx;
    logic [PRE_W-1:0] presc;
    logic             slot_free;
    logic             in_fire;
    logic [WIDTH-1:0] sweep_a;
    logic [WIDTH-1:0] sweep_b;

    function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = ~(a & b);
            3'd2:    r = a | b;
            3'd3:    r = ~(a | b);
            3'd4:    r = a ^ b;
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // The slot may be refilled in the same cycle its current result is consumed.
    assign slot_free = !OUT_VALID || OUT_READY;
    assign IN_READY  = !RST && (state == ST_IDLE) && slot_free;
    assign in_fire   = IN_VALID && IN_READY;
    assign sweep_a   = sweep_idx[WIDTH-1:0];
    assign sweep_b   = sweep_idx[IDX_W-1:WIDTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            sweep_idx  <= '0;
            presc      <= '0;
            Y          <= '0;
            Y_A        <= '0;
            Y_B        <= '0;
            OUT_VALID  <= 1'b0;
            SWEEP_DONE <= 1'b0;
        end else begin
            SWEEP_DONE <= 1'b0;
            if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        Y         <= gate_fn(OP, A, B);
                        Y_A       <= A;
                        Y_B       <= B;
                        OUT_VALID <= 1'b1;
                    end
                    if (SWEEP && !OUT_VALID) begin
                        state     <= ST_SWEEP_RUN;
                        sweep_idx <= '0;
                        presc     <= '0;
                    end
                end
                ST_SWEEP_RUN: begin
                    if (!SWEEP) begin
                        state <= ST_DRAIN;
                    end else if (presc == PRE_TC) begin
                        // Back-pressure parks the prescaler at terminal count.
                        if (slot_free) begin
                            Y          <= gate_fn(OP, sweep_a, sweep_b);
                            Y_A        <= sweep_a;
                            Y_B        <= sweep_b;
                            OUT_VALID  <= 1'b1;
                            sweep_idx  <= sweep_idx + IDX_W'(1);
                            presc      <= '0;
                            SWEEP_DONE <= &sweep_idx;
                        end
                    end else begin
                        presc <= presc + PRE_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (slot_free) begin
                        state     <= ST_IDLE;
                        sweep_idx <= '0;
                        presc     <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
